// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the stream_tx link driver.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned BURST_CNT_W = 8;
    localparam int unsigned TX_CNT_W    = 32;

    // Occupancy counter width: one extra bit so a full FIFO is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
module sync_fifo
    import stream_pkg::*;
#(
    parameter  int unsigned DATA_W     = DEF_DATA_W,
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW         = $clog2(FIFO_DEPTH),
    localparam int unsigned CW         = cnt_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_wr;
    logic              w_rd;

    assign full    = (r_count == CW'(FIFO_DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A full FIFO refuses writes even when a read happens on the same edge.
    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/stream_tx.sv
// Buffers upstream ready/valid words and drives them onto a valid-only link
// in bursts of BURST_LEN beats separated by GAP_CYC idle cycles.
module stream_tx
    import stream_pkg::*;
#(
    parameter  int unsigned DATA_W     = DEF_DATA_W,
    parameter  int unsigned FIFO_DEPTH = 8,
    parameter  int unsigned BURST_LEN  = 4,
    parameter  int unsigned GAP_CYC    = 2,
    localparam int unsigned CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic                enable,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_vld,
    output logic [CNT_W-1:0]    fifo_cnt,
    output logic [TX_CNT_W-1:0] tx_cnt,
    output logic                busy
);

    localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(BURST_LEN);
    localparam logic [BURST_CNT_W-1:0] LAST_GAP  =
        BURST_CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    tx_state_e              r_state;
    tx_state_e              w_state_nxt;
    logic [BURST_CNT_W-1:0] r_burst_cnt;
    logic [BURST_CNT_W-1:0] w_burst_nxt;
    logic [BURST_CNT_W-1:0] r_gap_cnt;
    logic [BURST_CNT_W-1:0] w_gap_nxt;
    logic [BURST_CNT_W-1:0] w_beat;

    logic [DATA_W-1:0]      r_data_out;
    logic                   r_data_vld;
    logic [TX_CNT_W-1:0]    r_tx_cnt;

    logic [DATA_W-1:0]      w_head;
    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (in_vld),
        .wr_data (in_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_pop    = enable && !w_empty && (r_state != GAP);
    assign in_rdy   = !w_full;
    assign fifo_cnt = w_count;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign data_out = r_data_out;
    assign data_vld = r_data_vld;
    assign tx_cnt   = r_tx_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    // Beat number the current pop completes; IDLE always starts a fresh burst.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_beat      = (r_state == IDLE) ? BURST_CNT_W'(1)
                                        : r_burst_cnt + BURST_CNT_W'(1);
        unique case (r_state)
            IDLE, SEND: begin
                if (w_pop) begin
                    if (w_beat == LAST_BEAT) begin
                        w_burst_nxt = '0;
                        w_state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
                    end else begin
                        w_burst_nxt = w_beat;
                        w_state_nxt = SEND;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == LAST_GAP) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt   = r_gap_cnt + BURST_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_burst_nxt = '0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // Link registers: data_out holds its last word between pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_data_vld <= 1'b0;
            r_tx_cnt   <= '0;
        end else begin
            r_data_vld <= w_pop;
            if (w_pop) begin
                r_data_out <= w_head;
                r_tx_cnt   <= r_tx_cnt + TX_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_tx.sv
// Self-checking bench for stream_tx: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the link.
module tb_stream_tx;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BL    = 4;
    localparam int unsigned GAPC  = 2;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_vld  = 1'b0;
    logic          in_rdy;
    logic          enable  = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_vld;
    logic [3:0]    fifo_cnt;
    logic [31:0]   tx_cnt;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of buffered words, beats in current burst, gap cycles left.
    logic [DW-1:0] m_q[$];
    int            m_beats;
    int            m_gap;
    logic          m_vld;
    logic [DW-1:0] m_data;
    logic [31:0]   m_tx;

    always #5 clk = ~clk;

    stream_tx #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BL),
        .GAP_CYC    (GAPC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .enable   (enable),
        .data_out (data_out),
        .data_vld (data_vld),
        .fifo_cnt (fifo_cnt),
        .tx_cnt   (tx_cnt),
        .busy     (busy)
    );

    task automatic model_reset();
        m_q.delete();
        m_beats = 0;
        m_gap   = 0;
        m_vld   = 1'b0;
        m_data  = '0;
        m_tx    = '0;
    endtask

    // One clock edge of the link, using the inputs currently applied.
    task automatic model_step();
        bit do_push;
        do_push = in_vld && (m_q.size() < int'(DEPTH));
        if (enable && (m_q.size() > 0) && (m_gap == 0)) begin
            m_data  = m_q.pop_front();
            m_vld   = 1'b1;
            m_tx    = m_tx + 32'd1;
            m_beats = m_beats + 1;
            if (m_beats == int'(BL)) begin
                m_beats = 0;
                m_gap   = int'(GAPC);
            end
        end else begin
            m_vld = 1'b0;
            if (m_gap > 0) m_gap = m_gap - 1;
        end
        if (do_push) m_q.push_back(in_data);
    endtask

    function automatic logic m_busy();
        return (m_beats != 0) || (m_gap != 0) || (m_q.size() != 0);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld  = 1'b0;
        enable  = 1'b0;
        in_data = '0;
        reset_n = 1'b0;
        model_reset();
        #2;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (data_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got %0b want 0", data_vld); end
        n_checks++; if (data_out !== '0) begin n_errors++; $display("FAIL reset_data got %h want 0", data_out); end
        n_checks++; if (tx_cnt !== '0) begin n_errors++; $display("FAIL reset_tx_cnt got %0d want 0", tx_cnt); end
        n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); end
        n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_in_rdy got %0b want 1", in_rdy); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (data_vld !== 1'b0 || busy !== 1'b0 || fifo_cnt !== '0) begin
                n_errors++; $display("FAIL idle_quiet cyc %0d got vld=%0b busy=%0b cnt=%0d want 0 0 0", k, data_vld, busy, fifo_cnt);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        enable  = 1'b1;
        in_vld  = 1'b1;
        in_data = 32'hDEADBEEF;
        tick();
        in_vld = 1'b0;
        n_checks++; if (data_vld !== 1'b0) begin n_errors++; $display("FAIL single_e0_vld got %0b want 0", data_vld); end
        n_checks++; if (fifo_cnt !== 4'd1) begin n_errors++; $display("FAIL single_e0_cnt got %0d want 1", fifo_cnt); end
        tick();
        n_checks++; if (data_vld !== 1'b1) begin n_errors++; $display("FAIL single_e1_vld got %0b want 1", data_vld); end
        n_checks++; if (data_out !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_e1_data got %h want deadbeef", data_out); end
        n_checks++; if (tx_cnt !== 32'd1) begin n_errors++; $display("FAIL single_tx_cnt got %0d want 1", tx_cnt); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_mid_burst got %0b want 1", busy); end
        tick();
        n_checks++; if (data_vld !== 1'b0) begin n_errors++; $display("FAIL single_e2_vld got %0b want 0", data_vld); end
        n_checks++; if (data_out !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_hold_data got %h want deadbeef", data_out); end
    endtask

    task automatic test_burst();
        logic [DW-1:0] nxt;
        logic          exp_v;
        do_reset();
        enable = 1'b1;
        nxt    = 32'd1;
        for (int k = 0; k < 12; k++) begin
            in_vld  = (k < 8);
            in_data = 32'(k + 1);
            tick();
            exp_v = ((k >= 1) && (k <= 4)) || ((k >= 7) && (k <= 10));
            n_checks++; if (data_vld !== exp_v) begin n_errors++; $display("FAIL burst_pattern edge %0d got %0b want %0b", k, data_vld, exp_v); end
            if (data_vld === 1'b1) begin
                n_checks++; if (data_out !== nxt) begin n_errors++; $display("FAIL burst_data edge %0d got %0d want %0d", k, data_out, nxt); end
                nxt = nxt + 32'd1;
            end
        end
        in_vld = 1'b0;
        n_checks++; if (tx_cnt !== 32'd8) begin n_errors++; $display("FAIL burst_tx_cnt got %0d want 8", tx_cnt); end
    endtask

    task automatic test_enable_full();
        logic [DW-1:0] nxt;
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_vld  = 1'b1;
            in_data = 32'h100 + 32'(i);
            n_checks++; if (in_rdy !== 1'b1) begin n_errors++; $display("FAIL fill_rdy word %0d got %0b want 1", i, in_rdy); end
            tick();
        end
        in_data = 32'h108;
        n_checks++; if (in_rdy !== 1'b0) begin n_errors++; $display("FAIL full_rdy got %0b want 0", in_rdy); end
        tick();
        tick();
        n_checks++; if (fifo_cnt !== 4'd8) begin n_errors++; $display("FAIL full_cnt got %0d want 8", fifo_cnt); end
        n_checks++; if (data_vld !== 1'b0) begin n_errors++; $display("FAIL disabled_vld got %0b want 0", data_vld); end
        enable = 1'b1;
        tick();
        n_checks++; if (fifo_cnt !== 4'd7) begin n_errors++; $display("FAIL full_pop_no_write cnt got %0d want 7", fifo_cnt); end
        n_checks++; if (data_vld !== 1'b1 || data_out !== 32'h100) begin n_errors++; $display("FAIL first_pop got vld=%0b data=%h want 1 100", data_vld, data_out); end
        tick();
        in_vld = 1'b0;
        n_checks++; if (fifo_cnt !== 4'd7) begin n_errors++; $display("FAIL ninth_accept cnt got %0d want 7", fifo_cnt); end
        n_checks++; if (data_vld !== 1'b1 || data_out !== 32'h101) begin n_errors++; $display("FAIL second_pop got vld=%0b data=%h want 1 101", data_vld, data_out); end
        nxt = 32'h102;
        for (int k = 0; k < 30 && nxt != 32'h109; k++) begin
            tick();
            if (data_vld === 1'b1) begin
                n_checks++; if (data_out !== nxt) begin n_errors++; $display("FAIL drain_order got %h want %h", data_out, nxt); end
                nxt = nxt + 32'd1;
            end
        end
        n_checks++; if (nxt !== 32'h109) begin n_errors++; $display("FAIL drain_timeout next %h want 109", nxt); end
        n_checks++; if (tx_cnt !== 32'd9) begin n_errors++; $display("FAIL drain_tx_cnt got %0d want 9", tx_cnt); end
    endtask

    task automatic test_underrun();
        bit            exp_pat [12] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0};
        logic [DW-1:0] words   [5]  = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        int            widx;
        widx = 0;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_vld = (k == 0) || (k == 1) || (k == 5) || (k == 6) || (k == 7);
            case (k)
                0: in_data = 32'hA;
                1: in_data = 32'hB;
                5: in_data = 32'hC;
                6: in_data = 32'hD;
                7: in_data = 32'hE;
                default: in_data = 32'hFFFF_FFFF;
            endcase
            tick();
            n_checks++; if (data_vld !== exp_pat[k]) begin n_errors++; $display("FAIL underrun_pattern edge %0d got %0b want %0b", k, data_vld, exp_pat[k]); end
            if (data_vld === 1'b1 && widx < 5) begin
                n_checks++; if (data_out !== words[widx]) begin n_errors++; $display("FAIL underrun_data edge %0d got %h want %h", k, data_out, words[widx]); end
                widx++;
            end
            if (k == 4) begin
                n_checks++; if (busy !== 1'b1 || fifo_cnt !== '0) begin n_errors++; $display("FAIL underrun_busy got busy=%0b cnt=%0d want 1 0", busy, fifo_cnt); end
            end
        end
        in_vld = 1'b0;
        n_checks++; if (tx_cnt !== 32'd5) begin n_errors++; $display("FAIL underrun_tx_cnt got %0d want 5", tx_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] nxt;
        logic          exp_v;
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_vld  = 1'b1;
            in_data = 32'h200 + 32'(i);
            tick();
        end
        in_vld = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        n_checks++; if (fifo_cnt !== 4'd5 || data_vld !== 1'b1 || data_out !== 32'h201) begin
            n_errors++; $display("FAIL mid_setup got cnt=%0d vld=%0b data=%h want 5 1 201", fifo_cnt, data_vld, data_out);
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (data_vld !== 1'b0) begin n_errors++; $display("FAIL mid_rst_vld got %0b want 0", data_vld); end
        n_checks++; if (data_out !== '0) begin n_errors++; $display("FAIL mid_rst_data got %h want 0", data_out); end
        n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL mid_rst_cnt got %0d want 0", fifo_cnt); end
        n_checks++; if (tx_cnt !== '0) begin n_errors++; $display("FAIL mid_rst_tx got %0d want 0", tx_cnt); end
        n_checks++; if (busy !== 1'b0 || in_rdy !== 1'b1) begin n_errors++; $display("FAIL mid_rst_flags got busy=%0b rdy=%0b want 0 1", busy, in_rdy); end
        #2 reset_n = 1'b1;
        nxt = 32'h55;
        for (int k = 0; k < 10; k++) begin
            in_vld  = (k < 5);
            in_data = 32'h55 + 32'(k);
            tick();
            exp_v = ((k >= 1) && (k <= 4)) || (k == 7);
            n_checks++; if (data_vld !== exp_v) begin n_errors++; $display("FAIL post_rst_pattern edge %0d got %0b want %0b", k, data_vld, exp_v); end
            if (data_vld === 1'b1) begin
                n_checks++; if (data_out !== nxt) begin n_errors++; $display("FAIL post_rst_data got %h want %h", data_out, nxt); end
                nxt = nxt + 32'd1;
            end
        end
        in_vld = 1'b0;
        n_checks++; if (tx_cnt !== 32'd5) begin n_errors++; $display("FAIL post_rst_tx got %0d want 5", tx_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 400; k++) begin
            in_vld  = ($urandom_range(9) < 7);
            in_data = $urandom;
            if ($urandom_range(7) == 0) enable = ~enable;
            tick();
            n_checks++; if (data_vld !== m_vld) begin n_errors++; $display("FAIL rand_vld cyc %0d got %0b want %0b", k, data_vld, m_vld); end
            n_checks++; if (data_out !== m_data) begin n_errors++; $display("FAIL rand_data cyc %0d got %h want %h", k, data_out, m_data); end
            n_checks++; if (tx_cnt !== m_tx) begin n_errors++; $display("FAIL rand_tx cyc %0d got %0d want %0d", k, tx_cnt, m_tx); end
            n_checks++; if (fifo_cnt !== 4'(m_q.size())) begin n_errors++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", k, fifo_cnt, m_q.size()); end
            n_checks++; if (in_rdy !== (m_q.size() != int'(DEPTH))) begin n_errors++; $display("FAIL rand_rdy cyc %0d got %0b", k, in_rdy); end
            n_checks++; if (busy !== m_busy()) begin n_errors++; $display("FAIL rand_busy cyc %0d got %0b want %0b", k, busy, m_busy()); end
        end
        in_vld = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_enable_full();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
